tmr_scrub_ctrl: RTL and testbench
=================================

Name: tmr_scrub_ctrl

Overview:
- Scrub scheduler and write arbiter for a bank of DEPTH triplicated (TMR) storage words, each word having copies A/B/C.
- Periodically walks every address, reads all three copies, bitwise majority-votes them and writes the voted word back to all copies on mismatch. This clears accumulated single-copy upsets before a second hit makes them uncorrectable.
- Shares the bank write port between host writes (priority) and scrub writebacks.
- Reports corrected and uncorrectable event counts.

Parameters:
- WIDTH, 8, data bits per word.
- DEPTH, 16, number of TMR words; power of two, at least 2.
- AW, $clog2(DEPTH), address width.
- INTERVAL, 64, idle cycles between scrub steps; at least 1.
- CNT_W, 16, error counter width.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous reset, active high.
- EN  in  1  scrub enable. Host arbitration works regardless of EN.
- rd_en  out  1  bank read strobe.
- rd_addr  out  AW  bank read address.
- rd_a, rd_b, rd_c  in  WIDTH each  copy data, valid the cycle after rd_en.
- host_req  in  1  host write request.
- host_addr  in  AW  host write address.
- host_data  in  WIDTH  host write data.
- host_gnt  out  1  combinational; equals host_req.
- wr_en  out  1  bank write strobe; writes all three copies.
- wr_addr  out  AW  bank write address.
- wr_data  out  WIDTH  bank write data.
- corr_cnt  out  CNT_W  corrected-word count, saturating.
- unc_cnt  out  CNT_W  uncorrectable-word count, saturating.
- err_flag  out  1  sticky; set on any mismatch.
- scan_done  out  1  one-cycle pulse when address DEPTH-1 finishes its step.

Behaviour:
- Reset values: state IDLE, timer 0, scrub address 0. rd_en, wr_en, err_flag, scan_done, corr_cnt, unc_cnt all 0. rd_addr and wr_addr 0.
- FSM states: IDLE, READ, CAPT, VOTE, WB, NEXT.
- IDLE:
  - EN=0: timer held at 0.
  - EN=1: timer increments; when timer==INTERVAL-1, go to READ and clear the timer.
- READ: rd_en=1 and rd_addr=scrub address for exactly one cycle; go to CAPT.
- CAPT: register rd_a, rd_b, rd_c; go to VOTE.
- VOTE:
  - voted = (a&b)|(b&c)|(a&c).
  - mismatch = (a!=b)|(b!=c).
  - unc = (a!=b)&(b!=c)&(a!=c).
  - No mismatch: go to NEXT.
  - Mismatch: set err_flag.
  - unc=1: unc_cnt+1 and go to NEXT with no writeback. The voted value is not trusted.
  - Otherwise: corr_cnt+1 and go to WB.
- WB:
  - If host_req=0: wr_en=1, wr_addr=scrub address, wr_data=voted; go to NEXT.
  - If host_req=1: the host owns the port; stay in WB.
  - If host_req=1 and host_addr equals the scrub address, the pending writeback is cancelled (host data is newer); go to NEXT.
- NEXT: increment scrub address modulo DEPTH. When wrapping from DEPTH-1 to 0, pulse scan_done. Go to IDLE.
- Host path:
  - When host_req=1: wr_en=1, wr_addr=host_addr, wr_data=host_data in that same cycle. Combinational, zero latency, any state.
  - Host always wins the write port.
- Host write hitting the word under scrub while in CAPT or VOTE: discard the captured copies. No count, no writeback; go to NEXT.
- EN deasserted mid-step: the current step completes through NEXT, then the FSM holds in IDLE.
- Counters saturate at 2^CNT_W-1; they do not wrap.
- err_flag and the counters clear only on RST.
- RST mid-operation: everything returns to reset values next edge; any pending writeback is dropped.
- Step length without contention: 4 cycles, READ through NEXT, for a clean word.
- Full scan period without contention: DEPTH*(INTERVAL+4) cycles clean; +1 cycle per corrected word.

Decomposition:
- Package tmr_scrub_pkg:
  - state enum (IDLE, READ, CAPT, VOTE, WB, NEXT);
  - function maj3(a,b,c) for WIDTH-bit bitwise majority;
  - function classify(a,b,c) returning {mismatch, unc}.
- One natural sub-module, tmr_sat_counter (parameter CNT_W; inputs CLK, RST, inc; output cnt), instantiated twice for corr_cnt and unc_cnt.

Test Plan:
- Clean bank: DEPTH=4, INTERVAL=2, all copies 8'h5A, EN=1 -> no wr_en; scan_done pulses every 24 cycles; both counters stay 0; err_flag stays 0.
- Single-copy upset: addr 2 holds A=8'h5A, B=8'h5B, C=8'h5A -> wr_en with wr_addr=2 and wr_data=8'h5A, 3 cycles after READ; corr_cnt=1; err_flag=1; unc_cnt=0.
- Uncorrectable: addr 1 holds A=8'h01, B=8'h02, C=8'h04 -> no writeback; unc_cnt=1; corr_cnt=0; err_flag=1.
- Host contention in WB: host_req held high for 3 cycles to addr 3 while the scrub is in WB for addr 2 -> host writes occur in those 3 cycles; scrub writeback of addr 2 occurs on the 4th cycle.
- Host collision: host writes addr 2 with data 8'hFF while the scrub is in VOTE for addr 2 (mismatched copies) -> only the host write of 8'hFF occurs; corr_cnt stays unchanged.
- Saturation and reset: CNT_W=2 with 5 corrected words -> corr_cnt=3. Assert RST in WB -> next cycle all outputs are 0, no wr_en, and the FSM is in IDLE.

Source files
------------

// File: rtl/tmr_scrub_pkg.sv
// Shared types and voting helpers for the TMR scrub controller.
// Voting functions work on a fixed wide vector; callers zero-extend narrower words.
package tmr_scrub_pkg;

  localparam int unsigned VOTE_W = 64;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    CAPT = 3'd2,
    VOTE = 3'd3,
    WB   = 3'd4,
    NEXT = 3'd5
  } scrub_state_e;

  typedef struct packed {
    logic mismatch;
    logic unc;
  } vote_class_t;

  function automatic logic [VOTE_W-1:0] maj3(input logic [VOTE_W-1:0] a,
                                             input logic [VOTE_W-1:0] b,
                                             input logic [VOTE_W-1:0] c);
    return (a & b) | (b & c) | (a & c);
  endfunction

  function automatic vote_class_t classify(input logic [VOTE_W-1:0] a,
                                           input logic [VOTE_W-1:0] b,
                                           input logic [VOTE_W-1:0] c);
    vote_class_t r;
    r.mismatch = (a != b) | (b != c);
    r.unc      = (a != b) & (b != c) & (a != c);
    return r;
  endfunction

endpackage

// File: rtl/tmr_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module tmr_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // next count, held at the ceiling
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/tmr_scrub_ctrl.sv
// Scrub scheduler: walks the TMR bank, votes each word and writes corrected
// data back, while host writes always take the shared write port first.
module tmr_scrub_ctrl
  import tmr_scrub_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AW       = $clog2(DEPTH),
  parameter int INTERVAL = 64,
  parameter int CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  output logic             rd_en,
  output logic [AW-1:0]    rd_addr,
  input  logic [WIDTH-1:0] rd_a,
  input  logic [WIDTH-1:0] rd_b,
  input  logic [WIDTH-1:0] rd_c,
  input  logic             host_req,
  input  logic [AW-1:0]    host_addr,
  input  logic [WIDTH-1:0] host_data,
  output logic             host_gnt,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [WIDTH-1:0] wr_data,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] unc_cnt,
  output logic             err_flag,
  output logic             scan_done
);

  localparam int TW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;

  scrub_state_e     state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] cap_a_q, cap_a_d, cap_b_q, cap_b_d, cap_c_q, cap_c_d;
  logic             err_q, err_d;
  logic             rd_en_q, rd_en_d;
  logic [AW-1:0]    rd_addr_q, rd_addr_d;
  logic             scan_done_q, scan_done_d;
  logic             corr_inc, unc_inc, host_hit;
  logic [WIDTH-1:0] voted;
  vote_class_t      vclass;

  assign host_hit = host_req && (host_addr == addr_q);
  assign voted    = WIDTH'(maj3(VOTE_W'(cap_a_q), VOTE_W'(cap_b_q), VOTE_W'(cap_c_q)));
  assign vclass   = classify(VOTE_W'(cap_a_q), VOTE_W'(cap_b_q), VOTE_W'(cap_c_q));

  // scrub sequencing, capture, voting decisions and registered read strobes
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    addr_d   = addr_q;
    cap_a_d  = cap_a_q;
    cap_b_d  = cap_b_q;
    cap_c_d  = cap_c_q;
    err_d    = err_q;
    corr_inc = 1'b0;
    unc_inc  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!EN) begin
          timer_d = {TW{1'b0}};
        end else if (timer_q == TW'(INTERVAL - 1)) begin
          timer_d = {TW{1'b0}};
          state_d = READ;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      READ: state_d = CAPT;
      CAPT: begin
        // a host write to this word makes the in-flight read stale
        if (host_hit) begin
          state_d = NEXT;
        end else begin
          cap_a_d = rd_a;
          cap_b_d = rd_b;
          cap_c_d = rd_c;
          state_d = VOTE;
        end
      end
      VOTE: begin
        if (host_hit || !vclass.mismatch) begin
          state_d = NEXT;
        end else if (vclass.unc) begin
          err_d   = 1'b1;
          unc_inc = 1'b1;
          state_d = NEXT;
        end else begin
          err_d    = 1'b1;
          corr_inc = 1'b1;
          state_d  = WB;
        end
      end
      WB: begin
        if (!host_req || host_hit) begin
          state_d = NEXT;
        end else begin
          state_d = WB;
        end
      end
      NEXT: begin
        addr_d  = addr_q + AW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    rd_en_d     = (state_d == READ);
    rd_addr_d   = rd_en_d ? addr_d : {AW{1'b0}};
    scan_done_d = (state_d == NEXT) && (addr_d == AW'(DEPTH - 1));
  end

  // write port: host first, then a pending scrub writeback
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = {AW{1'b0}};
    wr_data = {WIDTH{1'b0}};
    if (host_req) begin
      wr_en   = 1'b1;
      wr_addr = host_addr;
      wr_data = host_data;
    end else if (state_q == WB) begin
      wr_en   = 1'b1;
      wr_addr = addr_q;
      wr_data = voted;
    end else begin
      wr_en   = 1'b0;
    end
  end

  // state and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      timer_q     <= {TW{1'b0}};
      addr_q      <= {AW{1'b0}};
      cap_a_q     <= {WIDTH{1'b0}};
      cap_b_q     <= {WIDTH{1'b0}};
      cap_c_q     <= {WIDTH{1'b0}};
      err_q       <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= {AW{1'b0}};
      scan_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      addr_q      <= addr_d;
      cap_a_q     <= cap_a_d;
      cap_b_q     <= cap_b_d;
      cap_c_q     <= cap_c_d;
      err_q       <= err_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      scan_done_q <= scan_done_d;
    end
  end

  tmr_sat_counter #(.CNT_W(CNT_W)) u_corr_cnt (
    .CLK (CLK),
    .RST (RST),
    .inc (corr_inc),
    .cnt (corr_cnt)
  );

  tmr_sat_counter #(.CNT_W(CNT_W)) u_unc_cnt (
    .CLK (CLK),
    .RST (RST),
    .inc (unc_inc),
    .cnt (unc_cnt)
  );

  assign host_gnt  = host_req;
  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign err_flag  = err_q;
  assign scan_done = scan_done_q;

endmodule

// File: tb/tb_tmr_scrub_ctrl.sv
// Bench for tmr_scrub_ctrl: behavioural bank plus a step-level reference model,
// directed scenarios followed by randomized host traffic, upsets and resets.
module tb_tmr_scrub_ctrl;

  localparam int WIDTH    = 8;
  localparam int DEPTH    = 4;
  localparam int AW       = 2;
  localparam int INTERVAL = 2;
  localparam int CNT_W    = 2;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;
  localparam int PERIOD   = DEPTH * (INTERVAL + 4);

  logic             CLK = 1'b0;
  logic             RST, EN;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_a, rd_b, rd_c;
  logic             host_req;
  logic [AW-1:0]    host_addr;
  logic [WIDTH-1:0] host_data;
  logic             host_gnt, wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [CNT_W-1:0] corr_cnt, unc_cnt;
  logic             err_flag, scan_done;

  always #5 CLK = ~CLK;

  tmr_scrub_ctrl #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .INTERVAL(INTERVAL), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .RST(RST), .EN(EN),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_a(rd_a), .rd_b(rd_b), .rd_c(rd_c),
    .host_req(host_req), .host_addr(host_addr), .host_data(host_data),
    .host_gnt(host_gnt), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .corr_cnt(corr_cnt), .unc_cnt(unc_cnt), .err_flag(err_flag), .scan_done(scan_done)
  );

  logic [WIDTH-1:0] bank_a [DEPTH];
  logic [WIDTH-1:0] bank_b [DEPTH];
  logic [WIDTH-1:0] bank_c [DEPTH];
  logic             prev_rd_en, prev_wr_en;
  logic [AW-1:0]    prev_rd_addr, prev_wr_addr;
  logic [WIDTH-1:0] prev_wr_data;

  int n_vec = 0;
  int n_miscmp = 0;
  int cyc = 0;
  int last_scan = -1;
  bit chk_period = 1'b0;

  // step-level reference model state
  bit               m_busy, m_end, m_wb, m_err;
  int               m_pos, m_wait, m_addr, m_corr, m_unc;
  logic [WIDTH-1:0] m_a, m_b, m_c;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_vote(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [WIDTH-1:0] c);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = ((int'(a[i]) + int'(b[i]) + int'(c[i])) >= 2);
    end
    return r;
  endfunction

  function automatic int n_distinct(input logic [WIDTH-1:0] a,
                                    input logic [WIDTH-1:0] b,
                                    input logic [WIDTH-1:0] c);
    int n;
    n = 1;
    if (b != a) n++;
    if ((c != a) && (c != b)) n++;
    return n;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_end = 1'b0; m_wb = 1'b0; m_err = 1'b0;
    m_pos = 0; m_wait = 0; m_addr = 0; m_corr = 0; m_unc = 0;
    m_a = '0; m_b = '0; m_c = '0;
  endtask

  // advance the model across one clock edge using the inputs of this cycle
  task automatic model_step();
    bit hit;
    hit = host_req && (int'(host_addr) == m_addr);
    if (RST) begin
      model_reset();
    end else if (!m_busy) begin
      if (!EN) m_wait = 0;
      else if (m_wait == INTERVAL - 1) begin
        m_wait = 0; m_busy = 1'b1; m_pos = 0; m_end = 1'b0; m_wb = 1'b0;
      end else m_wait++;
    end else if (m_end) begin
      m_addr = (m_addr + 1) % DEPTH;
      m_busy = 1'b0;
      m_end  = 1'b0;
    end else if (m_wb) begin
      if (!host_req || hit) begin
        m_wb = 1'b0; m_end = 1'b1;
      end
    end else if (m_pos == 0) begin
      m_pos = 1;
    end else if (hit) begin
      m_end = 1'b1;
    end else if (m_pos == 1) begin
      m_a = rd_a; m_b = rd_b; m_c = rd_c; m_pos = 2;
    end else begin
      case (n_distinct(m_a, m_b, m_c))
        1: m_end = 1'b1;
        3: begin
          if (m_unc < CNT_MAX) m_unc++;
          m_err = 1'b1; m_end = 1'b1;
        end
        default: begin
          if (m_corr < CNT_MAX) m_corr++;
          m_err = 1'b1; m_wb = 1'b1;
        end
      endcase
    end
  endtask

  // bank reacts to last cycle's strobes: read returns pre-write data
  task automatic bank_apply();
    if (prev_rd_en) begin
      rd_a = bank_a[prev_rd_addr];
      rd_b = bank_b[prev_rd_addr];
      rd_c = bank_c[prev_rd_addr];
    end
    if (prev_wr_en) begin
      bank_a[prev_wr_addr] = prev_wr_data;
      bank_b[prev_wr_addr] = prev_wr_data;
      bank_c[prev_wr_addr] = prev_wr_data;
    end
  endtask

  task automatic run_cycle();
    logic             e_rd_en, e_wb, e_wen, e_scan;
    logic [AW-1:0]    e_rd_addr, e_waddr;
    logic [WIDTH-1:0] e_wdata;
    #1;
    e_rd_en   = m_busy && !m_end && !m_wb && (m_pos == 0);
    e_rd_addr = e_rd_en ? AW'(m_addr) : '0;
    e_scan    = m_busy && m_end && (m_addr == DEPTH - 1);
    e_wb      = m_busy && m_wb;
    e_wen     = host_req || e_wb;
    e_waddr   = host_req ? host_addr : (e_wb ? AW'(m_addr) : '0);
    e_wdata   = host_req ? host_data : (e_wb ? ref_vote(m_a, m_b, m_c) : '0);
    check("host_gnt",  32'(host_gnt),  32'(host_req));
    check("rd_en",     32'(rd_en),     32'(e_rd_en));
    check("rd_addr",   32'(rd_addr),   32'(e_rd_addr));
    check("wr_en",     32'(wr_en),     32'(e_wen));
    check("wr_addr",   32'(wr_addr),   32'(e_waddr));
    check("wr_data",   32'(wr_data),   32'(e_wdata));
    check("scan_done", 32'(scan_done), 32'(e_scan));
    check("corr_cnt",  32'(corr_cnt),  32'(m_corr));
    check("unc_cnt",   32'(unc_cnt),   32'(m_unc));
    check("err_flag",  32'(err_flag),  32'(m_err));
    if (chk_period && scan_done) begin
      if (last_scan >= 0) check("scan_period", cyc - last_scan, PERIOD);
      last_scan = cyc;
    end
    prev_rd_en   = rd_en;
    prev_rd_addr = rd_addr;
    prev_wr_en   = wr_en;
    prev_wr_addr = wr_addr;
    prev_wr_data = wr_data;
    model_step();
    cyc++;
    @(negedge CLK);
    bank_apply();
  endtask

  task automatic quiet_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      host_req = 1'b0;
      RST = 1'b0;
      run_cycle();
    end
  endtask

  task automatic inject_upset();
    int ad, kind;
    logic [WIDTH-1:0] m1;
    ad   = int'($urandom_range(DEPTH - 1, 0));
    kind = int'($urandom_range(4, 0));
    m1   = WIDTH'($urandom_range(254, 1));
    case (kind)
      0: bank_a[ad] = bank_a[ad] ^ m1;
      1: bank_b[ad] = bank_b[ad] ^ m1;
      2: bank_c[ad] = bank_c[ad] ^ m1;
      3: begin bank_b[ad] = bank_b[ad] ^ m1; bank_c[ad] = bank_c[ad] ^ m1; end
      default: begin bank_b[ad] = bank_a[ad] ^ m1; bank_c[ad] = bank_a[ad] ^ ~m1; end
    endcase
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit found;
    int burst;
    int c0;
    RST = 1'b1; EN = 1'b0; host_req = 1'b0; host_addr = '0; host_data = '0;
    rd_a = '0; rd_b = '0; rd_c = '0;
    prev_rd_en = 1'b0; prev_wr_en = 1'b0;
    prev_rd_addr = '0; prev_wr_addr = '0; prev_wr_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      bank_a[i] = 8'h5A; bank_b[i] = 8'h5A; bank_c[i] = 8'h5A;
    end
    model_reset();
    @(negedge CLK);
    for (int i = 0; i < 2; i++) begin RST = 1'b1; run_cycle(); end

    // clean bank: fixed scan period, no writes, counters idle
    EN = 1'b1;
    chk_period = 1'b1;
    quiet_cycles(4 * PERIOD + 4);
    chk_period = 1'b0;

    // single-copy upset at addr 2
    bank_b[2] = 8'h5B;
    quiet_cycles(2 * PERIOD);
    check("upset_corr", 32'(corr_cnt), 32'd1);

    // uncorrectable word at addr 1
    bank_a[1] = 8'h01; bank_b[1] = 8'h02; bank_c[1] = 8'h04;
    quiet_cycles(PERIOD + 2);
    check("unc_seen", 32'(unc_cnt), 32'd1);

    // host holds the port for 3 cycles while addr 2 waits to write back
    bank_c[2] = bank_c[2] ^ 8'h80;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (m_busy && m_wb) found = 1'b1;
      else quiet_cycles(1);
    end
    check("reach_wb", 32'(found), 32'd1);
    host_addr = 2'd3; host_data = 8'hC3;
    for (int k = 0; k < 3; k++) begin host_req = 1'b1; run_cycle(); end
    host_req = 1'b0;
    run_cycle();
    quiet_cycles(4);

    // host write to the word being voted cancels the correction
    bank_a[2] = bank_a[2] ^ 8'h04;
    c0 = m_corr;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (m_busy && !m_end && !m_wb && (m_pos == 2) && (m_addr == 2)) found = 1'b1;
      else quiet_cycles(1);
    end
    check("reach_vote", 32'(found), 32'd1);
    host_req = 1'b1; host_addr = 2'd2; host_data = 8'hFF;
    run_cycle();
    quiet_cycles(6);
    check("coll_corr", 32'(corr_cnt), 32'(c0));

    // three more corrections push the 2-bit counter into saturation
    bank_a[0] = bank_a[0] ^ 8'h01;
    bank_b[2] = bank_b[2] ^ 8'h02;
    bank_c[3] = bank_c[3] ^ 8'h04;
    quiet_cycles(2 * PERIOD + 4);
    check("corr_sat", 32'(corr_cnt), 32'd3);

    // reset while a writeback is pending
    bank_b[0] = bank_b[0] ^ 8'h10;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (m_busy && m_wb) found = 1'b1;
      else quiet_cycles(1);
    end
    check("reach_wb_rst", 32'(found), 32'd1);
    host_req = 1'b0; RST = 1'b1;
    run_cycle();
    RST = 1'b0;
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_err", 32'(err_flag), 32'd0);
    quiet_cycles(2);

    // randomized traffic, upsets, EN drops and resets
    burst = 0;
    for (int k = 0; k < 3000; k++) begin
      if (!m_busy && ($urandom_range(5, 0) == 0)) inject_upset();
      EN = ($urandom_range(15, 0) != 0);
      if (burst > 0) begin
        host_req = 1'b1;
        burst--;
      end else if ($urandom_range(7, 0) == 0) begin
        host_req  = 1'b1;
        burst     = int'($urandom_range(2, 0));
        host_addr = ($urandom_range(1, 0) == 0) ? AW'(m_addr) : AW'($urandom_range(DEPTH - 1, 0));
        host_data = WIDTH'($urandom);
      end else begin
        host_req = 1'b0;
      end
      RST = (m_busy && m_wb && ($urandom_range(7, 0) == 0)) || ($urandom_range(399, 0) == 0);
      run_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
